// File: rtl/bbp_source_arbiter.sv
// Packet-granular two-source AXI-Stream arbiter for the transmit baseband datapath.
// S0 = PCIe H2C, S1 = 10G MAC RX; a watchdog closes packets whose owner stalls mid-packet.
module bbp_source_arbiter #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned KEEP_W  = 8,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_250m,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic [KEEP_W-1:0] s0_tkeep,
  input  logic              s0_tvalid,
  input  logic              s0_tlast,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic [KEEP_W-1:0] s1_tkeep,
  input  logic              s1_tvalid,
  input  logic              s1_tlast,
  output logic              s1_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  input  logic [1:0]        cfg_en,
  input  logic              cfg_fixed_prio,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1,
  output logic [CNT_W-1:0]  abort_cnt
);

  localparam int unsigned WD_W = $clog2(TIMEOUT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [1:0]        grant_nxt;
  logic              rr_last;
  logic              rr_last_nxt;
  logic [WD_W-1:0]   wdog;
  logic [WD_W-1:0]   wdog_nxt;
  logic              inc_pkt0;
  logic              inc_pkt1;
  logic              inc_abort;
  logic [1:0]        req;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;

  assign req       = cfg_en & {s1_tvalid, s0_tvalid};
  assign sel_valid = grant[1] ? s1_tvalid : s0_tvalid;
  assign sel_last  = grant[1] ? s1_tlast  : s0_tlast;
  assign sel_data  = grant[1] ? s1_tdata  : s0_tdata;
  assign sel_keep  = grant[1] ? s1_tkeep  : s0_tkeep;

  // State register
  always_ff @(posedge clk_250m or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state, arbitration, watchdog and datapath steering
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_last_nxt = rr_last;
    wdog_nxt    = wdog;
    inc_pkt0    = 1'b0;
    inc_pkt1    = 1'b0;
    inc_abort   = 1'b0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tdata     = '0;
    m_tkeep     = '0;
    s0_tready   = 1'b0;
    s1_tready   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req != 2'b00) begin
          state_nxt = ST_SEND;
          wdog_nxt  = '0;
          // rr_last=1 means S1 owned last, so S0 wins the tie
          if (req == 2'b11) grant_nxt = (cfg_fixed_prio || rr_last) ? 2'b01 : 2'b10;
          else              grant_nxt = req;
        end
      end
      ST_SEND: begin
        m_tvalid  = sel_valid;
        m_tlast   = sel_last;
        m_tdata   = sel_data;
        m_tkeep   = sel_keep;
        s0_tready = grant[0] & m_tready;
        s1_tready = grant[1] & m_tready;
        if (sel_valid) begin
          wdog_nxt = '0;
          if (m_tready && sel_last) begin
            state_nxt   = ST_IDLE;
            grant_nxt   = 2'b00;
            rr_last_nxt = grant[1];
            inc_pkt0    = grant[0];
            inc_pkt1    = grant[1];
          end
        end else if (wdog == WD_W'(TIMEOUT - 1)) begin
          state_nxt = ST_ABORT;
        end else begin
          wdog_nxt = wdog + WD_W'(1);
        end
      end
      ST_ABORT: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        if (m_tready) begin
          state_nxt   = ST_IDLE;
          grant_nxt   = 2'b00;
          rr_last_nxt = grant[1];
          inc_abort   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // Grant, round-robin pointer, watchdog and saturating statistics
  always_ff @(posedge clk_250m or negedge reset_n) begin
    if (!reset_n) begin
      grant     <= 2'b00;
      rr_last   <= 1'b1;
      wdog      <= '0;
      pkt_cnt0  <= '0;
      pkt_cnt1  <= '0;
      abort_cnt <= '0;
    end else begin
      grant   <= grant_nxt;
      rr_last <= rr_last_nxt;
      wdog    <= wdog_nxt;
      if (inc_pkt0 && (pkt_cnt0 != '1))   pkt_cnt0  <= pkt_cnt0 + CNT_W'(1);
      if (inc_pkt1 && (pkt_cnt1 != '1))   pkt_cnt1  <= pkt_cnt1 + CNT_W'(1);
      if (inc_abort && (abort_cnt != '1)) abort_cnt <= abort_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bbp_source_arbiter.sv
// Scoreboard bench for bbp_source_arbiter: drivers push hand-ordered expected beats,
// a negedge monitor pops and compares every output handshake.
module tb_bbp_source_arbiter;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned KEEP_W  = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 4;

  logic              clk_250m = 1'b0;
  logic              reset_n;
  logic [DATA_W-1:0] s0_tdata, s1_tdata, m_tdata;
  logic [KEEP_W-1:0] s0_tkeep, s1_tkeep, m_tkeep;
  logic              s0_tvalid, s0_tlast, s0_tready;
  logic              s1_tvalid, s1_tlast, s1_tready;
  logic              m_tvalid, m_tlast, m_tready;
  logic [1:0]        cfg_en;
  logic              cfg_fixed_prio;
  logic [1:0]        grant;
  logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1, abort_cnt;

  typedef struct packed {
    logic [1:0]        grant;
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              is_abort;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    last_hs_cyc = 0;
  logic  hold_pend = 1'b0;
  logic [DATA_W+KEEP_W:0] hold_val;
  logic  watch_s0 = 1'b0;
  logic  s0_ready_seen = 1'b0;
  logic  toggle_done;

  bbp_source_arbiter #(
    .DATA_W(DATA_W), .KEEP_W(KEEP_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_250m(clk_250m), .reset_n(reset_n),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast),
    .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast),
    .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .cfg_en(cfg_en), .cfg_fixed_prio(cfg_fixed_prio), .grant(grant),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .abort_cnt(abort_cnt)
  );

  always #2 clk_250m = ~clk_250m;
  always @(posedge clk_250m) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic beat_t mk(input int src, input int pkt, input int b, input bit last);
    beat_t t;
    t.grant    = (src == 0) ? 2'b01 : 2'b10;
    t.data     = {8'(src), 24'(pkt), 32'(b)};
    t.keep     = last ? 8'h0F : 8'hFF;
    t.last     = last;
    t.is_abort = 1'b0;
    return t;
  endfunction

  task automatic push_pkt(input int src, input int pkt, input int total);
    for (int b = 0; b < total; b++) exp_q.push_back(mk(src, pkt, b, b == total - 1));
  endtask

  task automatic put(input int src, input beat_t b, input logic v);
    if (src == 0) begin
      s0_tvalid = v; s0_tdata = b.data; s0_tkeep = b.keep; s0_tlast = b.last;
    end else begin
      s1_tvalid = v; s1_tdata = b.data; s1_tkeep = b.keep; s1_tlast = b.last;
    end
  endtask

  // Present beats first..lastb of a packet; each waits (bounded) for its handshake
  task automatic drive(input int src, input int pkt, input int first, input int lastb, input int total);
    beat_t bt;
    for (int b = first; b <= lastb; b++) begin
      bt = mk(src, pkt, b, b == total - 1);
      put(src, bt, 1'b1);
      for (int n = 0; ; n++) begin
        @(negedge clk_250m);
        if ((src == 0) ? s0_tready : s1_tready) break;
        if (n > 300) begin
          checks++; errors++;
          $display("FAIL drive_timeout: src %0d pkt %0d beat %0d never accepted", src, pkt, b);
          break;
        end
      end
      @(posedge clk_250m); #1;
    end
    bt = '0;
    put(src, bt, 1'b0);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk_250m);
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk_250m);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst grant", 64'(grant), 64'd0);
    check("rst m_tvalid", 64'(m_tvalid), 64'd0);
    repeat (2) @(posedge clk_250m);
    #1 reset_n = 1'b1;
  endtask

  // Scoreboard monitor and stall-stability checker
  always @(negedge clk_250m) begin
    if (!reset_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && m_tvalid)
        check("stall hold", 64'({m_tdata, m_tkeep, m_tlast} != hold_val), 64'd0);
      hold_pend = m_tvalid && !m_tready;
      hold_val  = {m_tdata, m_tkeep, m_tlast};
      if (watch_s0 && s0_tready) s0_ready_seen = 1'b1;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: data %0h grant %0b with empty queue", m_tdata, grant);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat data", m_tdata, e.data);
          check("beat keep", 64'(m_tkeep), 64'(e.keep));
          check("beat last", 64'(m_tlast), 64'(e.last));
          check("beat grant", 64'(grant), 64'(e.grant));
          if (e.is_abort) check("abort delay", 64'(cyc - last_hs_cyc), 64'd17);
        end
        last_hs_cyc = cyc;
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clk_250m);
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    beat_t ab;
    s0_tdata = '0; s0_tkeep = '0; s0_tvalid = 1'b0; s0_tlast = 1'b0;
    s1_tdata = '0; s1_tkeep = '0; s1_tvalid = 1'b0; s1_tlast = 1'b0;
    m_tready = 1'b1; cfg_en = 2'b11; cfg_fixed_prio = 1'b0;
    do_reset();
    check("rst s0_tready", 64'(s0_tready), 64'd0);
    check("rst pkt_cnt0", 64'(pkt_cnt0), 64'd0);

    // 1: lone S0 packet, one-cycle arbitration latency
    push_pkt(0, 1, 3);
    fork
      drive(0, 1, 0, 2, 3);
      begin
        @(negedge clk_250m);
        check("t1 grant before", 64'(grant), 64'd0);
        @(negedge clk_250m);
        check("t1 grant", 64'(grant), 64'd1);
        check("t1 s0_tready", 64'(s0_tready), 64'd1);
      end
    join
    drain("t1 drain");
    check("t1 pkt_cnt0", 64'(pkt_cnt0), 64'd1);
    check("t1 pkt_cnt1", 64'(pkt_cnt1), 64'd0);

    // 2: round-robin alternation
    do_reset();
    push_pkt(0, 1, 2); push_pkt(1, 1, 2); push_pkt(0, 2, 2); push_pkt(1, 2, 2);
    fork
      begin drive(0, 1, 0, 1, 2); drive(0, 2, 0, 1, 2); end
      begin drive(1, 1, 0, 1, 2); drive(1, 2, 0, 1, 2); end
    join
    drain("t2 drain");
    check("t2 pkt_cnt0", 64'(pkt_cnt0), 64'd2);
    check("t2 pkt_cnt1", 64'(pkt_cnt1), 64'd2);

    // 3: fixed priority, then S0 disabled
    do_reset();
    cfg_fixed_prio = 1'b1;
    push_pkt(0, 1, 2); push_pkt(0, 2, 2); push_pkt(1, 1, 2); push_pkt(1, 2, 2);
    fork
      begin drive(0, 1, 0, 1, 2); drive(0, 2, 0, 1, 2); end
      begin drive(1, 1, 0, 1, 2); drive(1, 2, 0, 1, 2); end
    join
    drain("t3 drain");
    cfg_en = 2'b10;
    watch_s0 = 1'b1;
    s0_tvalid = 1'b1; s0_tdata = 64'hDEAD; s0_tkeep = 8'hFF; s0_tlast = 1'b1;
    push_pkt(1, 3, 1);
    drive(1, 3, 0, 0, 1);
    drain("t3 en drain");
    check("t3 s0 never ready", 64'(s0_ready_seen), 64'd0);
    check("t3 idle grant", 64'(grant), 64'd0);
    check("t3 pkt_cnt0", 64'(pkt_cnt0), 64'd2);
    watch_s0 = 1'b0;
    s0_tvalid = 1'b0; cfg_en = 2'b11; cfg_fixed_prio = 1'b0;

    // 4: 8-beat S1 packet under toggling backpressure
    do_reset();
    push_pkt(1, 4, 8);
    toggle_done = 1'b0;
    fork
      begin drive(1, 4, 0, 7, 8); toggle_done = 1'b1; end
      begin
        while (!toggle_done) begin @(posedge clk_250m); #1 m_tready = ~m_tready; end
        m_tready = 1'b1;
      end
    join
    drain("t4 drain");
    check("t4 abort_cnt", 64'(abort_cnt), 64'd0);
    check("t4 pkt_cnt1", 64'(pkt_cnt1), 64'd1);

    // 5: watchdog closes a stalled S0 packet; the tail goes out as a new packet
    do_reset();
    exp_q.push_back(mk(0, 5, 0, 1'b0));
    exp_q.push_back(mk(0, 5, 1, 1'b0));
    ab = '0; ab.grant = 2'b01; ab.last = 1'b1; ab.is_abort = 1'b1;
    exp_q.push_back(ab);
    drive(0, 5, 0, 1, 3);
    drain("t5 abort drain");
    check("t5 abort_cnt", 64'(abort_cnt), 64'd1);
    check("t5 pkt_cnt0 after abort", 64'(pkt_cnt0), 64'd0);
    exp_q.push_back(mk(0, 5, 2, 1'b1));
    drive(0, 5, 2, 2, 3);
    drain("t5 tail drain");
    check("t5 pkt_cnt0", 64'(pkt_cnt0), 64'd1);

    // 6: counter saturation, then asynchronous reset mid-packet
    do_reset();
    for (int p = 0; p < 16; p++) begin
      push_pkt(1, p, 1);
      drive(1, p, 0, 0, 1);
      if (p == 14) begin
        drain("t6 drain15");
        check("t6 pkt_cnt1 max", 64'(pkt_cnt1), 64'd15);
      end
    end
    drain("t6 drain16");
    check("t6 pkt_cnt1 saturated", 64'(pkt_cnt1), 64'd15);
    m_tready = 1'b0;
    s0_tvalid = 1'b1; s0_tdata = 64'h1234; s0_tkeep = 8'hFF; s0_tlast = 1'b0;
    repeat (3) @(negedge clk_250m);
    check("t6 grant mid", 64'(grant), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("t6 async grant", 64'(grant), 64'd0);
    check("t6 async m_tvalid", 64'(m_tvalid), 64'd0);
    check("t6 async m_tdata", m_tdata, 64'd0);
    check("t6 async m_tkeep", 64'(m_tkeep), 64'd0);
    check("t6 async s0_tready", 64'(s0_tready), 64'd0);
    check("t6 async pkt_cnt1", 64'(pkt_cnt1), 64'd0);
    s0_tvalid = 1'b0;
    m_tready = 1'b1;
    @(posedge clk_250m); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk_250m);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
